// File: rtl/fib_pkg.sv
// fib_pkg: shared constants and FSM state type for the Fibonacci index finder.
//   WIDTH   : operand width of value / fib_floor
//   AW      : internal width of the a/b Fibonacci registers (one guard bit,
//             b reaches F(48) which does not fit in WIDTH bits)
//   IDX_W   : width of the index output
//   MAX_IDX : largest n with F(n) < 2**WIDTH (tied to WIDTH, not free)
package fib_pkg;

  localparam int WIDTH = 32;
  localparam int AW    = WIDTH + 1;
  localparam int IDX_W = 6;

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(47);

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

endpackage : fib_pkg

// File: rtl/fib_step.sv
// fib_step: purely combinational single Fibonacci step plus compare.
//   a, b     in  AW     current pair F(k), F(k+1)
//   value    in  WIDTH  operand being searched for
//   next_a   out AW     F(k+1)
//   next_b   out AW     F(k+2) (only meaningful while it fits AW bits)
//   eq       out 1      a == value
//   gt       out 1      a >  value
// The operand is zero-extended to AW bits, so compares never wrap.
module fib_step
  import fib_pkg::*;
(
  input  logic [AW-1:0]    a,
  input  logic [AW-1:0]    b,
  input  logic [WIDTH-1:0] value,
  output logic [AW-1:0]    next_a,
  output logic [AW-1:0]    next_b,
  output logic             eq,
  output logic             gt
);

  logic [AW-1:0] value_ext;

  assign value_ext = {1'b0, value};
  assign next_a    = b;
  assign next_b    = a + b;
  assign eq        = (a == value_ext);
  assign gt        = (a > value_ext);

endmodule : fib_step

// File: rtl/fib_index_finder.sv
// fib_index_finder: inverse Fibonacci lookup. Given a WIDTH-bit value it walks
// the sequence one step per clock and reports n with F(n) == value, or flags
// the value as non-Fibonacci and reports n of the largest F(n) below it.
//   clk        in   1      clock, all state on rising edge
//   reset      in   1      synchronous, active-high; abandons any search
//   start      in   1      request, sampled only while busy == 0
//   value      in   WIDTH  operand, captured on accepted start
//   busy       out  1      search in progress
//   done       out  1      one-cycle pulse, results valid from this cycle
//   is_fib     out  1      value is a Fibonacci number
//   index      out  IDX_W  hit: n; miss: n of largest F(n) < value
//   fib_floor  out  WIDTH  largest F(n) <= value
// Optional feature macro: FIB_INDEX_FLOOR_EN. When undefined fib_floor is
// tied to zero and no floor register exists.
module fib_index_finder
  import fib_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             is_fib,
  output logic [IDX_W-1:0] index,
  output logic [WIDTH-1:0] fib_floor
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] value_reg;
  logic [AW-1:0]    a_reg, b_reg;
  logic [IDX_W-1:0] k_reg;
  logic             done_reg, is_fib_reg;
  logic [IDX_W-1:0] index_reg;

  logic [AW-1:0]    step_a, step_b;
  logic             eq, gt, at_cap;
  logic             accept, resolve;

  fib_step u_step (
    .a      (a_reg),
    .b      (b_reg),
    .value  (value_reg),
    .next_a (step_a),
    .next_b (step_b),
    .eq     (eq),
    .gt     (gt)
  );

  assign at_cap  = (k_reg == MAX_IDX);
  assign accept  = (state_reg == IDLE) && start;
  // Any of the three terminating conditions ends the search this cycle.
  assign resolve = (state_reg == SEARCH) && (eq || gt || at_cap);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)   state_next = SEARCH;
      SEARCH:  if (resolve) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    if (state_reg == SEARCH) busy = 1'b1;
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg  <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      k_reg      <= '0;
      done_reg   <= 1'b0;
      is_fib_reg <= 1'b0;
      index_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        value_reg  <= value;
        a_reg      <= '0;
        b_reg      <= AW'(1);
        k_reg      <= '0;
        is_fib_reg <= 1'b0;
        index_reg  <= '0;
      end else if (state_reg == SEARCH) begin
        if (eq) begin
          done_reg   <= 1'b1;
          is_fib_reg <= 1'b1;
          index_reg  <= k_reg;
        end else if (gt) begin
          // k >= 2 here: a = F(0) or F(1) can only exceed a value of 0,
          // which already hit at k = 0.
          done_reg   <= 1'b1;
          index_reg  <= k_reg - IDX_W'(1);
        end else if (at_cap) begin
          done_reg   <= 1'b1;
          index_reg  <= MAX_IDX;
        end else begin
          a_reg <= step_a;
          b_reg <= step_b;
          k_reg <= k_reg + IDX_W'(1);
        end
      end
    end
  end

  assign done   = done_reg;
  assign is_fib = is_fib_reg;
  assign index  = index_reg;

`ifdef FIB_INDEX_FLOOR_EN
  logic [WIDTH-1:0] floor_reg;
  logic [WIDTH-1:0] prev_a;

  // On a gt miss a = F(k), b = F(k+1), so F(k-1) = b - a. The true result
  // fits WIDTH bits, so a modulo-2**WIDTH subtraction is exact even when
  // b carries the guard bit.
  assign prev_a = b_reg[WIDTH-1:0] - a_reg[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      floor_reg <= '0;
    end else if (accept) begin
      floor_reg <= '0;
    end else if (state_reg == SEARCH) begin
      if (eq)          floor_reg <= value_reg;
      else if (gt)     floor_reg <= prev_a;
      else if (at_cap) floor_reg <= a_reg[WIDTH-1:0];
    end
  end

  assign fib_floor = floor_reg;
`else
  assign fib_floor = '0;
`endif

endmodule : fib_index_finder

// File: tb/tb_fib_index_finder.sv
// Directed bench for fib_index_finder: hand-computed vectors covering zero,
// the index-1 ambiguity, a miss, the 32-bit cap (hit and miss), start while
// busy, back-to-back start in the done cycle, and reset mid-search.
module tb_fib_index_finder;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        is_fib;
  logic [5:0]  index;
  logic [31:0] fib_floor;

  int n_checks = 0;
  int n_fail   = 0;

  fib_index_finder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .value     (value),
    .busy      (busy),
    .done      (done),
    .is_fib    (is_fib),
    .index     (index),
    .fib_floor (fib_floor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] floor_exp(input logic [31:0] f);
`ifdef FIB_INDEX_FLOOR_EN
    return f;
`else
    if (f == 32'd0) return 32'd0;  // keeps argument used in both builds
    return 32'd0;
`endif
  endfunction

  // Called right after a posedge (+#1) with start/value already set for the
  // accepting edge. Returns in the done cycle (or after the time budget).
  task automatic run_search(input string tag, input logic [31:0] v,
                            input int exp_cyc, input bit exp_fib,
                            input int exp_idx, input logic [31:0] exp_floor,
                            input bit inject, input bit check_drop);
    int cyc  = 0;
    bit seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    for (int i = 1; i <= 60 && !seen; i++) begin
      if (i > 1) begin
        @(posedge clk); #1;
      end else begin
        // first compare edge follows on the next clock
        @(posedge clk); #1;
      end
      start = 1'b0;
      if (inject && (i == 1 || i == 2)) begin
        start = 1'b1;
        value = 32'd8;
      end
      if (done) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " is_fib"}, 64'(is_fib), 64'(exp_fib));
    check({tag, " index"}, 64'(index), 64'(exp_idx));
    check({tag, " fib_floor"}, 64'(fib_floor), 64'(floor_exp(exp_floor)));
    check({tag, " busy_in_done"}, 64'(busy), 64'd0);
    $display("search %s value=%0d: cycles=%0d is_fib=%0d index=%0d fib_floor=%0d",
             tag, v, cyc, is_fib, index, fib_floor);
    if (check_drop) begin
      @(posedge clk); #1;
      check({tag, " done_one_cycle"}, 64'(done), 64'd0);
      check({tag, " index_held"}, 64'(index), 64'(exp_idx));
    end
  endtask

  task automatic launch(input logic [31:0] v);
    start = 1'b1;
    value = v;
  endtask

  int done_pulses;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset is_fib", 64'(is_fib), 64'd0);
    check("reset index", 64'(index), 64'd0);
    check("reset fib_floor", 64'(fib_floor), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    launch(32'd0);          run_search("v0",   32'd0,          1,  1'b1, 0,  32'd0,          1'b0, 1'b1);
    launch(32'd1);          run_search("v1",   32'd1,          2,  1'b1, 1,  32'd1,          1'b0, 1'b1);
    launch(32'd2);          run_search("v2",   32'd2,          4,  1'b1, 3,  32'd2,          1'b0, 1'b1);
    launch(32'd4);          run_search("v4",   32'd4,          6,  1'b0, 4,  32'd3,          1'b0, 1'b1);
    launch(32'd6);          run_search("v6",   32'd6,          7,  1'b0, 5,  32'd5,          1'b0, 1'b1);
    launch(32'd2971215073); run_search("f47",  32'd2971215073, 48, 1'b1, 47, 32'd2971215073, 1'b0, 1'b1);
    launch(32'hFFFFFFFF);   run_search("vmax", 32'hFFFFFFFF,   48, 1'b0, 47, 32'd2971215073, 1'b0, 1'b1);

    // start while busy is ignored, then back-to-back start in the done cycle
    launch(32'd21);         run_search("v21_busy", 32'd21,     9,  1'b1, 8,  32'd21,         1'b1, 1'b0);
    launch(32'd8);          run_search("v8_b2b",   32'd8,      7,  1'b1, 6,  32'd8,          1'b0, 1'b1);

    // reset in the middle of a long search
    launch(32'hFFFFFFFF);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("midrst busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst is_fib", 64'(is_fib), 64'd0);
    check("midrst index", 64'(index), 64'd0);
    check("midrst fib_floor", 64'(fib_floor), 64'd0);
    done_pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) done_pulses++;
    end
    check("midrst no_done", 64'(done_pulses), 64'd0);
    check("midrst idle_busy", 64'(busy), 64'd0);
    $display("reset mid-search: busy=%0d done_pulses=%0d", busy, done_pulses);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fib_index_finder
